// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the switch debouncer: per-channel FSM state encoding,
// default debounce length and the counter-width helper.
package switch_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_PEND_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_PEND_LO   = 2'd3
  } deb_state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;

  // The counter only ever holds 0..cycles-1, so $clog2(cycles) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchronizer, stability FSM and counter.
// Optional o_rise/o_fall pulses when SWITCH_DEBOUNCER_EDGE_EN is defined.
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_raw,
  output logic o_state,
  output logic o_stable
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  ,
  output logic o_rise,
  output logic o_fall
`endif
);

  localparam int unsigned      CNT_W       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam deb_state_e       RESET_STATE = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;

  logic             r_sync1;
  logic             r_sync2;
  deb_state_e       r_fsm;
  deb_state_e       w_fsm_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_state;
  logic             w_state_next;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fsm   <= RESET_STATE;
      r_cnt   <= '0;
      r_state <= RESET_LEVEL;
    end else begin
      r_fsm   <= w_fsm_next;
      r_cnt   <= w_cnt_next;
      r_state <= w_state_next;
    end
  end

  // Any bounce during a pending change drops straight back to the old stable
  // state with the counter cleared, so short glitches never accumulate.
  always_comb begin
    w_fsm_next   = r_fsm;
    w_cnt_next   = r_cnt;
    w_state_next = r_state;
    unique case (r_fsm)
      ST_STABLE_LO: begin
        if (r_sync2) begin
          w_fsm_next = ST_PEND_HI;
          w_cnt_next = CNT_W'(1);
        end
      end
      ST_PEND_HI: begin
        if (!r_sync2) begin
          w_fsm_next = ST_STABLE_LO;
          w_cnt_next = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_fsm_next   = ST_STABLE_HI;
          w_state_next = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_STABLE_HI: begin
        if (!r_sync2) begin
          w_fsm_next = ST_PEND_LO;
          w_cnt_next = CNT_W'(1);
        end
      end
      ST_PEND_LO: begin
        if (r_sync2) begin
          w_fsm_next = ST_STABLE_HI;
          w_cnt_next = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_fsm_next   = ST_STABLE_LO;
          w_state_next = 1'b0;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
    endcase
  end

  assign o_state  = r_state;
  assign o_stable = (r_fsm == ST_STABLE_LO) || (r_fsm == ST_STABLE_HI);

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic r_state_d;
  logic r_rise;
  logic r_fall;

  // r_state_d resets to the same level as r_state, so reset never yields a pulse.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state_d <= RESET_LEVEL;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_state_d <= r_state;
      r_rise    <= r_state & ~r_state_d;
      r_fall    <= ~r_state & r_state_d;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// NUM_CH independent switch debounce channels. Define SWITCH_DEBOUNCER_EDGE_EN
// to add the o_rise/o_fall one-cycle edge pulse outputs.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned NUM_CH          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [NUM_CH-1:0] i_raw,
  output logic [NUM_CH-1:0] o_state,
  output logic [NUM_CH-1:0] o_stable
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  ,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall
`endif
);

  logic [NUM_CH-1:0] w_state;
  logic [NUM_CH-1:0] w_stable;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_ch (
      .i_clock  (i_clock),
      .i_reset_n(i_reset_n),
      .i_raw    (i_raw[g]),
      .o_state  (w_state[g]),
      .o_stable (w_stable[g])
`ifdef SWITCH_DEBOUNCER_EDGE_EN
      ,
      .o_rise   (w_rise[g]),
      .o_fall   (w_fall[g])
`endif
    );
  end

  assign o_state  = w_state;
  assign o_stable = w_stable;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  assign o_rise   = w_rise;
  assign o_fall   = w_fall;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=8, NUM_CH=3, RESET_LEVEL=0.
// Edge-pulse checks are included when SWITCH_DEBOUNCER_EDGE_EN is defined.
module tb_switch_debouncer;

  logic       clk;
  logic       rst_n;
  logic [2:0] raw;
  logic [2:0] state;
  logic [2:0] stable;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic [2:0] rise;
  logic [2:0] fall;
`endif

  int checks = 0;
  int errors = 0;

  switch_debouncer #(
    .NUM_CH         (3),
    .DEBOUNCE_CYCLES(8),
    .RESET_LEVEL    (1'b0)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_raw    (raw),
    .o_state  (state),
    .o_stable (stable)
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    ,
    .o_rise   (rise),
    .o_fall   (fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with all inputs high
    rst_n = 1'b0;
    raw   = 3'b111;
    #1;
    chk("rst_state_async", state, 3'b000);
    step(3);
    chk("rst_state", state, 3'b000);
    chk("rst_stable", stable, 3'b111);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    chk("rst_rise", rise, 3'b000);
    chk("rst_fall", fall, 3'b000);
`endif
    rst_n = 1'b1;
    raw   = 3'b000;
    step(1);
    chk("post_rst_state", state, 3'b000);
    chk("post_rst_stable", stable, 3'b111);
    step(3);
    chk("idle_state", state, 3'b000);

    // 2: clean edge on channel 0, change lands on the 10th edge
    raw = 3'b001;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("clean_state", state, {2'b00, (k >= 10)});
      chk("clean_stable", stable, {2'b11, !(k >= 3 && k <= 9)});
`ifdef SWITCH_DEBOUNCER_EDGE_EN
      chk("clean_rise_early", rise, 3'b000);
`endif
    end
    step(1);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    chk("clean_rise_pulse", rise, 3'b001);
`endif
    chk("clean_hold", state, 3'b001);
    step(1);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    chk("clean_rise_end", rise, 3'b000);
`endif

    // 3: bounce on channel 1: high 5, low 2, then high
    raw = 3'b011;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk("bounce_hi1", state, 3'b001);
    end
    raw = 3'b001;
    for (int k = 1; k <= 2; k++) begin
      step(1);
      chk("bounce_lo", state, 3'b001);
    end
    raw = 3'b011;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("bounce_final", state, (k >= 10) ? 3'b011 : 3'b001);
    end
    step(10);
    chk("bounce_hold", state, 3'b011);
    chk("bounce_stable", stable, 3'b111);

    // 4: bring channel 2 high, then glitch it low
    raw = 3'b111;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("ch2_up", state, (k >= 10) ? 3'b111 : 3'b011);
    end
    step(2);
    raw = 3'b011;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      chk("glitch7_low", state, 3'b111);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
      chk("glitch7_fall", fall, 3'b000);
`endif
    end
    raw = 3'b111;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("glitch7_after", state, 3'b111);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
      chk("glitch7_fall2", fall, 3'b000);
`endif
    end
    chk("glitch7_stable", stable, 3'b111);

    // exactly 8 low cycles: fall on edge 10, re-rise on edge 18
    raw = 3'b011;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk("glitch8_low", state, 3'b111);
    end
    raw = 3'b111;
    step(1);
    chk("glitch8_e9", state, 3'b111);
    step(1);
    chk("glitch8_fall", state, 3'b011);
    step(1);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    chk("glitch8_fall_pulse", fall, 3'b100);
`endif
    for (int k = 12; k <= 18; k++) begin
      step(1);
      chk("glitch8_rerise", state, (k >= 18) ? 3'b111 : 3'b011);
    end
    step(2);

    // 5: all channels fall together
    raw = 3'b000;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("simul_state", state, (k >= 10) ? 3'b000 : 3'b111);
      if (k >= 3 && k <= 9) chk("simul_stable", stable, 3'b000);
    end
    step(1);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    chk("simul_fall", fall, 3'b111);
`endif
    step(2);

    // 6: reset mid-pend on channel 0, then full latency restarts
    raw = 3'b001;
    step(6);
    chk("midpend_stable", stable, 3'b110);
    rst_n = 1'b0;
    #1;
    chk("midpend_rst_state", state, 3'b000);
    chk("midpend_rst_stable", stable, 3'b111);
    step(2);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    chk("midpend_rst_rise", rise, 3'b000);
`endif
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("restart_state", state, {2'b00, (k >= 10)});
    end
    step(1);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    chk("restart_rise", rise, 3'b001);
`endif
    chk("restart_hold", state, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
